uart_tx_fsm: RTL and testbench

- UART transmitter: serialises one parallel byte into an 11-bit frame on a single line: start bit, 8 data bits LSB first, parity bit, stop bit.
- Transmit-side counterpart of the receiver FSM; uses the same 8-clocks-per-bit timing so the two interoperate directly.
- Contains the control FSM, bit-period counter, bit counter, shift register and parity generator. Sits between the host write interface and the serial line.

---
 rtl/uart_tx_fsm.sv | 133 +++++++++++++
 tb/tb_uart_tx_fsm.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, parity bit, stop bit.
// Line, busy and done are all registered, so the first start-bit cycle follows the accepting edge.
module uart_tx_fsm #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int unsigned CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS + 1) : 1;
    localparam logic        PAR_SEL = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_out_q, tx_out_d;
    logic                 busy_q, busy_d;
    logic                 tx_done_q, tx_done_d;
    logic                 bit_tick;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_out_q  <= 1'b1;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_out_q  <= tx_out_d;
            busy_q    <= busy_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign bit_tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Next-state, counters and registered-output precompute
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tx_done_d = 1'b0;
        tx_out_d  = 1'b1;
        busy_d    = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = bit_tick ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (tx_start) begin
                    state_d  = S_START;
                    shift_d  = data_in;
                    parity_d = (^data_in) ^ PAR_SEL;
                end
            end
            S_START: begin
                if (bit_tick) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = S_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_tick) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_tick) begin
                    state_d   = S_IDLE;
                    tx_done_d = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                cnt_d     = '0;
                bit_cnt_d = '0;
            end
        endcase

        // Line level is derived from the state being entered so tx_out is a clean flop output
        case (state_d)
            S_START:  tx_out_d = 1'b0;
            S_DATA:   tx_out_d = shift_d[0];
            S_PARITY: tx_out_d = parity_d;
            default:  tx_out_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign tx_out  = tx_out_q;
    assign busy    = busy_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: even-parity (u_even) and odd-parity (u_odd) instances
// checked cycle by cycle against a frame model built from the byte and parity mode.
module tb_uart_tx_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [7:0] data0, data1;
    logic       out0, busy0, done0;
    logic       out1, busy1, done1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    uart_tx_fsm #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY_ODD(0)) u_even (
        .clk(clk), .rst(rst), .tx_start(start0), .data_in(data0),
        .tx_out(out0), .busy(busy0), .tx_done(done0)
    );

    uart_tx_fsm #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY_ODD(1)) u_odd (
        .clk(clk), .rst(rst), .tx_start(start1), .data_in(data1),
        .tx_out(out1), .busy(busy1), .tx_done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected line level for each of the 88 cycles of a frame
    function automatic logic [87:0] model_frame(input logic [7:0] d, input bit odd);
        logic [10:0] bits;
        logic [87:0] f;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[k+1] = d[k];
        bits[9]  = (($countones(d) % 2) == 1) ^ odd;
        bits[10] = 1'b1;
        for (int i = 0; i < 88; i++) f[i] = bits[i/8];
        return f;
    endfunction

    // Drive a request at a negedge; returns just after the accepting edge
    task automatic accept(input int sel, input logic [7:0] d, input bit hold);
        @(negedge clk);
        if (sel == 1) begin start1 = 1'b1; data1 = d; end
        else          begin start0 = 1'b1; data0 = d; end
        @(posedge clk);
        #1;
        if (!hold) begin
            if (sel == 1) begin start1 = 1'b0; data1 = 8'($urandom); end
            else          begin start0 = 1'b0; data0 = 8'($urandom); end
        end
    endtask

    // Collect 88 frame cycles plus the following cycle; optional stray request at cycle inject
    task automatic run_frame(input int sel, input int inject, output logic [87:0] obs,
                             output int busy_n, output int done_n, output logic [2:0] after);
        busy_n = 0;
        done_n = 0;
        for (int i = 0; i < 88; i++) begin
            @(negedge clk);
            if (inject >= 0 && i == inject)     begin start0 = 1'b1; data0 = 8'h3C; end
            if (inject >= 0 && i == inject + 1) start0 = 1'b0;
            obs[i]  = (sel == 1) ? out1 : out0;
            busy_n += int'((sel == 1) ? busy1 : busy0);
            done_n += int'((sel == 1) ? done1 : done0);
        end
        @(negedge clk);
        after = (sel == 1) ? {out1, busy1, done1} : {out0, busy0, done0};
    endtask

    task automatic test_reset;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
        #1;
        n_checks++;
        if ({out0, busy0, done0, out1, busy1, done1} !== 6'b100100) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected 100100", {out0, busy0, done0, out1, busy1, done1});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if ({out0, busy0, done0, out1, busy1, done1} !== 6'b100100) begin
                n_fail++;
                $display("FAIL idle_cycle_%0d: got %b expected 100100", i, {out0, busy0, done0, out1, busy1, done1});
            end
        end
    endtask

    task automatic test_frames;
        logic [7:0]  d_tab [4] = '{8'hA5, 8'h01, 8'hA5, 8'h00};
        int          s_tab [4] = '{0, 0, 1, 1};
        logic [87:0] obs, exp;
        int          bn, dn, quiet;
        logic [2:0]  aft;
        for (int t = 0; t < 10; t++) begin
            int         sel;
            logic [7:0] d;
            if (t < 4) begin sel = s_tab[t]; d = d_tab[t]; end
            else       begin sel = int'($urandom_range(1, 0)); d = 8'($urandom); end
            exp = model_frame(d, sel == 1);
            accept(sel, d, 1'b0);
            run_frame(sel, -1, obs, bn, dn, aft);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL frame_line sel=%0d data=%h: got %h expected %h", sel, d, obs, exp);
            end
            n_checks++;
            if (obs[72] !== exp[72]) begin
                n_fail++;
                $display("FAIL parity_bit sel=%0d data=%h: got %b expected %b", sel, d, obs[72], exp[72]);
            end
            n_checks++;
            if (bn !== 88 || dn !== 0) begin
                n_fail++;
                $display("FAIL frame_busy sel=%0d data=%h: busy=%0d done=%0d expected 88/0", sel, d, bn, dn);
            end
            n_checks++;
            if (aft !== 3'b101) begin
                n_fail++;
                $display("FAIL done_cycle sel=%0d data=%h: got %b expected 101", sel, d, aft);
            end
            quiet = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if ({out0, busy0, done0, out1, busy1, done1} !== 6'b100100) quiet++;
            end
            n_checks++;
            if (quiet !== 0) begin
                n_fail++;
                $display("FAIL post_frame_idle sel=%0d: got %0d bad cycles expected 0", sel, quiet);
            end
        end
    endtask

    task automatic test_ignore_while_busy;
        logic [87:0] obs, exp;
        int          bn, dn, extra;
        logic [2:0]  aft;
        exp = model_frame(8'hA5, 1'b0);
        accept(0, 8'hA5, 1'b0);
        run_frame(0, 40, obs, bn, dn, aft);
        n_checks++;
        if (obs !== exp || bn !== 88) begin
            n_fail++;
            $display("FAIL ignore_frame: got %h busy=%0d expected %h busy=88", obs, bn, exp);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            extra += int'(busy0) + int'(done0);
        end
        n_checks++;
        if (dn + int'(aft[0]) + extra !== 1) begin
            n_fail++;
            $display("FAIL ignore_single_done: got %0d done/busy events after frame, expected 1 done", dn + int'(aft[0]) + extra);
        end
    endtask

    task automatic test_back_to_back;
        logic [87:0] obs1, obs2;
        int          bn1, dn1, bn2, dn2, t1, t2, extra;
        logic [2:0]  aft1, aft2;
        accept(0, 8'h55, 1'b1);
        run_frame(0, -1, obs1, bn1, dn1, aft1);
        t1 = cyc;
        data0 = 8'hAA;
        @(posedge clk);
        #1;
        run_frame(0, -1, obs2, bn2, dn2, aft2);
        t2 = cyc;
        start0 = 1'b0;
        n_checks++;
        if (obs1 !== model_frame(8'h55, 1'b0) || aft1 !== 3'b101) begin
            n_fail++;
            $display("FAIL b2b_frame1: got %h/%b expected %h/101", obs1, aft1, model_frame(8'h55, 1'b0));
        end
        n_checks++;
        if (obs2 !== model_frame(8'hAA, 1'b0) || aft2 !== 3'b101 || bn2 !== 88) begin
            n_fail++;
            $display("FAIL b2b_frame2: got %h/%b busy=%0d expected %h/101 busy=88", obs2, aft2, bn2, model_frame(8'hAA, 1'b0));
        end
        n_checks++;
        if (t2 - t1 !== 89) begin
            n_fail++;
            $display("FAIL b2b_done_spacing: got %0d expected 89", t2 - t1);
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            extra += int'(busy0) + int'(done0);
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL b2b_stop: got %0d activity cycles expected 0", extra);
        end
    endtask

    task automatic test_reset_mid_parity;
        logic [87:0] exp, obs;
        int          bn, dn, act;
        logic [2:0]  aft;
        exp = model_frame(8'hC3, 1'b0);
        accept(0, 8'hC3, 1'b0);
        repeat (76) @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b1 || out0 !== exp[75]) begin
            n_fail++;
            $display("FAIL parity_before_reset: got busy=%b line=%b expected 1/%b", busy0, out0, exp[75]);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({out0, busy0, done0} !== 3'b100) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected 100", {out0, busy0, done0});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        act = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            act += int'(busy0) + int'(done0) + int'(!out0);
        end
        n_checks++;
        if (act !== 0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %0d activity cycles expected 0", act);
        end
        exp = model_frame(8'h0F, 1'b0);
        accept(0, 8'h0F, 1'b0);
        run_frame(0, -1, obs, bn, dn, aft);
        n_checks++;
        if (obs !== exp || bn !== 88 || dn !== 0 || aft !== 3'b101) begin
            n_fail++;
            $display("FAIL frame_after_reset: got %h busy=%0d done=%0d after=%b expected %h 88 0 101", obs, bn, dn, aft, exp);
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_ignore_while_busy();
        test_back_to_back();
        test_reset_mid_parity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
